// File: rtl/vec_seq_if.sv
// rtl/vec_seq_if.sv - vec_seq instruction, memory handshake and control bundle
interface vec_seq_if #(
  parameter int IDXW = 3
);
  logic            Start;
  logic            CondEx;
  logic [1:0]      Op;
  logic [IDXW:0]   VecLen;
  logic            MemReady;
  logic            Abort;
  logic            Stall;
  logic [IDXW-1:0] ElemIdx;
  logic            VecWrite;
  logic            MemValid;
  logic            MemWrite;
  logic            AccClr;
  logic            AccEn;
  logic            RegWrite;
  logic            Done;
  logic            Fault;

  modport master (
    output Start, CondEx, Op, VecLen, MemReady, Abort,
    input  Stall, ElemIdx, VecWrite, MemValid, MemWrite, AccClr, AccEn, RegWrite, Done, Fault
  );

  modport slave (
    input  Start, CondEx, Op, VecLen, MemReady, Abort,
    output Stall, ElemIdx, VecWrite, MemValid, MemWrite, AccClr, AccEn, RegWrite, Done, Fault
  );
endinterface

// File: rtl/vec_seq.sv
// rtl/vec_seq.sv - vector instruction element sequencer with memory timeout fault
module vec_seq #(
  parameter int MAXLEN  = 8,
  parameter int IDXW    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic      clk,
  input  logic      reset,
  vec_seq_if.slave  bus
);
  localparam int              TOW      = $clog2(TIMEOUT + 1);
  localparam logic [IDXW:0]   MAXLEN_L = (IDXW + 1)'(MAXLEN);
  localparam logic [TOW-1:0]  TO_LAST  = TOW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [IDXW:0]   len_q, len_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic [TOW-1:0]  to_q, to_d;

  logic [IDXW:0]   eff_len;
  logic            is_mem;
  logic            last_elem;

  // Oversized requests are clamped to the register file's vector length.
  assign eff_len   = (bus.VecLen > MAXLEN_L) ? MAXLEN_L : bus.VecLen;
  assign is_mem    = (op_q == 2'b01) || (op_q == 2'b10);
  assign last_elem = ({1'b0, cnt_q} == (len_q - 1'b1));

  // State and instruction context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Next-state and per-element control decode.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    bus.Stall    = 1'b0;
    bus.ElemIdx  = '0;
    bus.VecWrite = 1'b0;
    bus.MemValid = 1'b0;
    bus.MemWrite = 1'b0;
    bus.AccClr   = 1'b0;
    bus.AccEn    = 1'b0;
    bus.RegWrite = 1'b0;
    bus.Done     = 1'b0;
    bus.Fault    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start && bus.CondEx) begin
          op_d  = bus.Op;
          len_d = eff_len;
          cnt_d = '0;
          to_d  = '0;
          if (eff_len == '0) begin
            // Empty vector retires immediately without touching the pipeline.
            bus.Done = 1'b1;
          end else begin
            bus.Stall  = 1'b1;
            bus.AccClr = (bus.Op == 2'b11);
            state_d    = RUN;
          end
        end
      end

      RUN: begin
        bus.ElemIdx = cnt_q;
        if (bus.Abort) begin
          // Flush wins over any completion or timeout this cycle.
          state_d = IDLE;
          cnt_d   = '0;
          to_d    = '0;
        end else if (!is_mem || bus.MemReady) begin
          bus.VecWrite = (op_q[1] == 1'b0);
          bus.AccEn    = (op_q == 2'b11);
          bus.MemValid = is_mem;
          bus.MemWrite = (op_q == 2'b10);
          to_d         = '0;
          cnt_d        = cnt_q + 1'b1;
          if (last_elem) begin
            bus.Done     = 1'b1;
            bus.RegWrite = (op_q == 2'b11);
            state_d      = IDLE;
            cnt_d        = '0;
          end else begin
            bus.Stall = 1'b1;
          end
        end else begin
          bus.Stall    = 1'b1;
          bus.MemValid = 1'b1;
          bus.MemWrite = (op_q == 2'b10);
          to_d         = to_q + 1'b1;
          if (to_q == TO_LAST) begin
            state_d = FAULT;
            to_d    = '0;
          end
        end
      end

      FAULT: begin
        bus.Fault = 1'b1;
        bus.Stall = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/vec_seq.md
VEC_SEQ -- requirements
Module: vec_seq

Interface
REQ-001 SHALL have parameter MAXLEN, default 8: maximum elements per vector instruction (power of two, 2..16).
REQ-002 SHALL have parameter IDXW, default 3: element index width, log2(MAXLEN).
REQ-003 SHALL have parameter TIMEOUT, default 15: max consecutive cycles waiting on MemReady before fault.
REQ-004 SHALL have ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  decoded vector instruction present.
- CondEx  in  1  condition check passed for the current instruction.
- Op  in  2  00 elementwise ALU, 01 load, 10 store, 11 reduce.
- VecLen  in  IDXW+1  element count.
- MemReady  in  1  memory accepts/returns the current element this cycle.
- Abort  in  1  flush current vector instruction.
- Stall  out  1  hold PC and instruction register.
- ElemIdx  out  IDXW  current element index.
- VecWrite  out  1  vector register element write enable.
- MemValid  out  1  element memory request.
- MemWrite  out  1  memory request is a store.
- AccClr  out  1  clear reduce accumulator.
- AccEn  out  1  accumulate current element.
- RegWrite  out  1  write reduce result to scalar register.
- Done  out  1  one-cycle pulse: instruction retires this cycle.
- Fault  out  1  memory timeout fault, sticky.

Function
REQ-005 SHALL implement states IDLE, RUN, FAULT.
REQ-006 SHALL accept an instruction in IDLE when Start=1 and CondEx=1 (accept cycle T0); Start is ignored in RUN and FAULT.
REQ-007 SHALL latch Op and effective length L = min(VecLen, MAXLEN) at T0; VecLen above MAXLEN clamps to MAXLEN.
REQ-008 SHALL, for L=0 at T0: Done=1, Stall=0, remain IDLE, no write enables asserted.
REQ-009 SHALL, for L>0 at T0: Stall=1, AccClr=1 if Op=11, next state RUN, element counter cleared to 0.
REQ-010 SHALL drive ElemIdx from the element counter in RUN; ElemIdx=0 outside RUN.
REQ-011 SHALL complete an element in RUN every cycle for Op 00/11, and only in cycles with MemReady=1 for Op 01/10.
REQ-012 SHALL assert MemValid=1 throughout RUN for Op 01/10, with MemWrite=1 for Op 10 only.
REQ-013 SHALL assert VecWrite=1 in element-completing cycles for Op 00 and Op 01; never for Op 10/11.
REQ-014 SHALL assert AccEn=1 in element-completing cycles for Op 11.
REQ-015 SHALL increment the counter on each completing element; the completing cycle with counter=L-1 is the last element.
REQ-016 SHALL, in the last-element cycle: Stall=0, Done=1, RegWrite=1 if Op=11, next state IDLE.
REQ-017 SHALL hold Stall=1 in every other RUN cycle.
REQ-018 SHALL, on Abort=1 in RUN: suppress all write/accumulate/memory outputs that cycle, Stall=0, Done=0, next state IDLE; Abort is ignored in IDLE and FAULT.
REQ-019 SHALL count consecutive RUN cycles with MemValid=1 and MemReady=0; the counter clears on any completing element and on leaving RUN.
REQ-020 SHALL transition to FAULT when that count reaches TIMEOUT while MemReady=0; FAULT holds Fault=1, Stall=1, all enables 0, until reset.
REQ-021 SHALL make MemReady=1 in the same cycle the count reaches TIMEOUT complete the element with no fault.
REQ-022 SHALL give Abort priority over MemReady and timeout in the same cycle.
REQ-023 SHALL drive write enables combinationally from state, latched Op and MemReady; no output depends on Start except in IDLE.

Reset
REQ-024 SHALL, on reset=1 at a clock edge in any state, enter IDLE and clear the element counter, timeout counter, latched Op/L and Fault.
REQ-025 SHALL hold all outputs at 0 after reset until the next accepted Start.
REQ-026 SHALL let reset mid-RUN discard the instruction with no further writes.

Verification
REQ-027 ALU: Start, CondEx=1, Op=00, VecLen=4 -> Stall 1,1,1,1,0 over T0..T4; VecWrite on T1..T4 with ElemIdx 0,1,2,3; Done at T4 only.
REQ-028 Load with waits: Op=01, VecLen=2, MemReady low 2 cycles per element -> MemValid continuous, VecWrite only on the ready cycles, Done on the 2nd ready cycle.
REQ-029 Reduce/clamp: Op=11, VecLen=12, MAXLEN=8 -> AccClr at T0, AccEn on T1..T8, RegWrite and Done at T8.
REQ-030 Edges: VecLen=0 -> Done at T0 and Stall=0 at T0; CondEx=0 with Start -> no Stall, no Done, no enables.
REQ-031 Timeout: Op=10, MemReady held 0 -> Fault=1 after TIMEOUT RUN cycles, Stall stays 1; reset -> IDLE with Fault=0.
REQ-032 Abort/reset: Abort at element 2 of Op=00, VecLen=6 -> no VecWrite that cycle, IDLE next; reset mid-RUN -> all outputs 0 next cycle.
